// File: rtl/approx_mult_pipe.sv
// approx_mult_pipe
//   Pipelined unsigned approximate multiplier with a per-transaction
//   exact/approximate mode. In approximate mode the partial-product bits
//   that fall in columns 0..APPROX_L-1 are dropped. A constant of half the
//   dropped range is added back to centre the error. Every result carries
//   its signed error (exact product minus delivered product).
//
// Parameters
//   WIDTH       operand width (4..16)
//   APPROX_L    number of low partial-product columns dropped (0..2*WIDTH-1)
//   PIPE_STAGES register slices from input to output, equal to the latency (1..4)
//
// Ports
//   clk, rst     rising-edge clock, synchronous active-high reset
//   in_valid     operands valid; in_ready: a transfer happens when both are 1
//   in_x, in_y   unsigned operands; in_approx selects approximate (1) / exact (0)
//   out_valid    result valid; out_ready: downstream accepts the result
//   out_z        product; out_approx: mode bit of this result
//   out_err      signed error, exact product minus out_z
//   out_count    saturating count of delivered results
module approx_mult_pipe #(
  parameter int WIDTH       = 8,
  parameter int APPROX_L    = 6,
  parameter int PIPE_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_x,
  input  logic [WIDTH-1:0]     in_y,
  input  logic                 in_approx,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   out_z,
  output logic                 out_approx,
  output logic [2*WIDTH-1:0]   out_err,
  output logic [15:0]          out_count
);

  localparam int PW   = 2 * WIDTH;
  localparam int C_SH = (APPROX_L > 0) ? APPROX_L - 1 : 0;
  localparam logic [PW-1:0] C_VAL = (APPROX_L > 0) ? (PW'(1) << C_SH) : '0;

  // One pipeline slice. The product is carried exact together with the
  // error term; the delivered value is formed as prod - err at the output.
  // This keeps the correction subtractor off the first stage and gives
  // out_err and out_z from the same registers.
  typedef struct packed {
    logic          approx;
    logic [PW-1:0] prod;
    logic [PW-1:0] err;
  } slice_t;

  slice_t                 slc_q [PIPE_STAGES];
  logic [PIPE_STAGES-1:0] vld_q;
  slice_t                 slc_in;
  logic [PW-1:0]          drop_sum;
  logic [PW-1:0]          prod_full;
  logic                   nonzero;
  logic                   adv;

  // Global stall: the whole pipe advances whenever the output slot is free
  // or is being drained this cycle.
  assign adv       = !out_valid || out_ready;
  assign in_ready  = adv;
  assign out_valid = vld_q[PIPE_STAGES-1];

  // Sum of the dropped partial-product bits (columns below APPROX_L).
  always_comb begin
    drop_sum = '0;
    for (int unsigned j = 0; j < unsigned'(WIDTH); j++) begin
      for (int unsigned i = 0; i < unsigned'(WIDTH); i++) begin
        if ((i + j) < unsigned'(APPROX_L)) begin
          drop_sum = drop_sum + (PW'(in_x[i] & in_y[j]) << (i + j));
        end
      end
    end
  end

  always_comb begin
    prod_full     = {{WIDTH{1'b0}}, in_x} * {{WIDTH{1'b0}}, in_y};
    nonzero       = (|in_x) && (|in_y);
    slc_in        = '0;
    slc_in.approx = in_approx;
    slc_in.prod   = prod_full;
    // A zero operand forces both product and error to zero, so the
    // rounding constant must not leak into the result.
    slc_in.err    = (in_approx && nonzero) ? (drop_sum - C_VAL) : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      for (int unsigned s = 0; s < unsigned'(PIPE_STAGES); s++) begin
        slc_q[s] <= '0;
      end
    end else if (adv) begin
      vld_q[0] <= in_valid;
      if (in_valid) begin
        slc_q[0] <= slc_in;
      end
      for (int unsigned s = 1; s < unsigned'(PIPE_STAGES); s++) begin
        vld_q[s] <= vld_q[s-1];
        slc_q[s] <= slc_q[s-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_count <= '0;
    end else if (out_valid && out_ready && (out_count != '1)) begin
      out_count <= out_count + 16'd1;
    end
  end

  assign out_z      = slc_q[PIPE_STAGES-1].prod - slc_q[PIPE_STAGES-1].err;
  assign out_err    = slc_q[PIPE_STAGES-1].err;
  assign out_approx = slc_q[PIPE_STAGES-1].approx;

endmodule

// File: tb/tb_approx_mult_pipe.sv
// Self-checking bench for approx_mult_pipe: default configuration plus
// (WIDTH=4, APPROX_L=0, PIPE_STAGES=1) and (WIDTH=16, APPROX_L=12, PIPE_STAGES=4).
module tb_approx_mult_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  // default instance
  logic        rst0 = 1'b1, iv0 = 1'b0, ir0, ia0 = 1'b0, ov0, or0 = 1'b1, oa0;
  logic [7:0]  x0 = '0, y0 = '0;
  logic [15:0] z0, e0, cnt0;
  // sweep instances share one reset
  logic        rsts = 1'b1;
  logic        iva = 1'b0, ira, iaa = 1'b0, ova, ora = 1'b1, oaa;
  logic [3:0]  xa = '0, ya = '0;
  logic [7:0]  za, ea;
  logic [15:0] cnta;
  logic        ivb = 1'b0, irb, iab = 1'b0, ovb, orb = 1'b1, oab;
  logic [15:0] xb = '0, yb = '0;
  logic [31:0] zb, eb;
  logic [15:0] cntb;

  approx_mult_pipe u_dut0 (
    .clk(clk), .rst(rst0), .in_valid(iv0), .in_ready(ir0), .in_x(x0), .in_y(y0),
    .in_approx(ia0), .out_valid(ov0), .out_ready(or0), .out_z(z0),
    .out_approx(oa0), .out_err(e0), .out_count(cnt0));

  approx_mult_pipe #(.WIDTH(4), .APPROX_L(0), .PIPE_STAGES(1)) u_duta (
    .clk(clk), .rst(rsts), .in_valid(iva), .in_ready(ira), .in_x(xa), .in_y(ya),
    .in_approx(iaa), .out_valid(ova), .out_ready(ora), .out_z(za),
    .out_approx(oaa), .out_err(ea), .out_count(cnta));

  approx_mult_pipe #(.WIDTH(16), .APPROX_L(12), .PIPE_STAGES(4)) u_dutb (
    .clk(clk), .rst(rsts), .in_valid(ivb), .in_ready(irb), .in_x(xb), .in_y(yb),
    .in_approx(iab), .out_valid(ovb), .out_ready(orb), .out_z(zb),
    .out_approx(oab), .out_err(eb), .out_count(cntb));

  int     wd [3] = '{8, 4, 16};
  int     al [3] = '{6, 0, 12};
  int     ps [3] = '{2, 1, 4};
  longint ez [3][64];
  longint ee [3][64];
  bit     ea_q [3][64];
  int     es [3][64];
  int     wp [3] = '{0, 0, 0};
  int     rp [3] = '{0, 0, 0};
  longint cm [3] = '{0, 0, 0};
  bit     lat_chk [3] = '{1'b1, 1'b1, 1'b1};

  task automatic chk(input string tag, input longint got, input longint exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: dropped sum as, for each set multiplier bit j, the multiplicand
  // reduced modulo 2^(L-j) and weighted by 2^j.
  task automatic model(input int k, input longint x, input longint y, input bit a,
                       output longint z, output longint e);
    longint mask, p, d, c;
    int L;
    L    = al[k];
    mask = (64'sd1 <<< (2 * wd[k])) - 1;
    p    = x * y;
    if (x == 0 || y == 0) begin
      z = 0; e = 0;
    end else if (!a) begin
      z = p; e = 0;
    end else begin
      d = 0;
      for (int j = 0; j < L; j++)
        if (((y >> j) & 1) == 1) d += (x % (64'sd1 <<< (L - j))) <<< j;
      c = (L > 0) ? (64'sd1 <<< (L - 1)) : 0;
      z = (p - d + c) & mask;
      e = (d - c) & mask;
    end
  endtask

  task automatic mon(input int k, input bit r, input bit iv, input bit ir,
                     input longint x, input longint y, input bit ia,
                     input bit ov, input bit ordy, input longint z, input longint e,
                     input bit oa, input longint cnt);
    longint mz, me;
    int s;
    if (r) begin
      rp[k] = wp[k];
      cm[k] = 0;
      return;
    end
    chk($sformatf("d%0d_count", k), cnt, cm[k]);
    if (ov) begin
      if (rp[k] == wp[k]) begin
        chk($sformatf("d%0d_spurious_valid", k), longint'(ov), 0);
      end else begin
        s = rp[k] % 64;
        chk($sformatf("d%0d_z", k), z, ez[k][s]);
        chk($sformatf("d%0d_err", k), e, ee[k][s]);
        chk($sformatf("d%0d_approx", k), longint'(oa), longint'(ea_q[k][s]));
        if (ordy) begin
          if (lat_chk[k]) chk($sformatf("d%0d_latency", k), longint'(cyc - es[k][s]), longint'(ps[k]));
          rp[k]++;
          cm[k] = (cm[k] == 65535) ? 65535 : cm[k] + 1;
        end
      end
    end
    if (iv && ir) begin
      model(k, x, y, ia, mz, me);
      s = wp[k] % 64;
      ez[k][s]   = mz;
      ee[k][s]   = me;
      ea_q[k][s] = ia;
      es[k][s]   = cyc;
      wp[k]++;
    end
  endtask

  always @(negedge clk) begin
    mon(0, rst0, iv0, ir0, longint'(x0), longint'(y0), ia0, ov0, or0,
        longint'(z0), longint'(e0), oa0, longint'(cnt0));
    mon(1, rsts, iva, ira, longint'(xa), longint'(ya), iaa, ova, ora,
        longint'(za), longint'(ea), oaa, longint'(cnta));
    mon(2, rsts, ivb, irb, longint'(xb), longint'(yb), iab, ovb, orb,
        longint'(zb), longint'(eb), oab, longint'(cntb));
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send0(input logic [7:0] x, input logic [7:0] y, input logic a);
    bit acc;
    int g;
    g = 0;
    iv0 = 1'b1; x0 = x; y0 = y; ia0 = a;
    do begin
      @(negedge clk);
      acc = ir0;
      g++;
      @(posedge clk);
      #1;
    end while (!acc && g < 100);
    if (!acc) chk("accept_timeout", longint'(ir0), 1);
    iv0 = 1'b0;
  endtask

  task automatic directed(input logic [7:0] x, input logic [7:0] y, input logic a,
                          input longint zx, input longint exx);
    int n;
    send0(x, y, a);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ov0 && n < 20);
    chk("dir_latency", longint'(n), 2);
    chk("dir_z", longint'(z0), zx);
    chk("dir_err", longint'(e0), exx);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int g;
    repeat (2) @(posedge clk);
    #1;
    rst0 = 1'b0;
    rsts = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", longint'(ov0), 0);
    chk("rst_out_z", longint'(z0), 0);
    chk("rst_out_err", longint'(e0), 0);
    chk("rst_out_approx", longint'(oa0), 0);
    chk("rst_out_count", longint'(cnt0), 0);
    chk("rst_in_ready", longint'(ir0), 1);
    @(posedge clk);
    #1;

    directed(8'd255, 8'd255, 1'b0, 65025, 0);
    directed(8'd255, 8'd255, 1'b1, 64736, 289);
    directed(8'd3, 8'd3, 1'b1, 32, 16'hFFE9);
    directed(8'd0, 8'd200, 1'b1, 0, 0);
    directed(8'd77, 8'd0, 1'b1, 0, 0);

    // stream with a three-cycle downstream stall
    rst0 = 1'b1;
    @(posedge clk);
    #1;
    rst0 = 1'b0;
    lat_chk[0] = 1'b0;
    fork
      begin
        for (int i = 0; i < 20; i++)
          send0(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
      end
      begin
        repeat (5) @(posedge clk);
        #1;
        or0 = 1'b0;
        repeat (3) begin
          @(negedge clk);
          chk("stall_in_ready", longint'(ir0), 0);
          @(posedge clk);
        end
        #1;
        or0 = 1'b1;
      end
    join
    g = 0;
    while (wp[0] != rp[0] && g < 50) begin
      @(negedge clk);
      g++;
    end
    chk("stream_drained", longint'(wp[0] - rp[0]), 0);
    @(negedge clk);
    chk("stream_count", longint'(cnt0), 20);
    @(posedge clk);
    #1;
    lat_chk[0] = 1'b1;

    // reset while two transactions are in flight
    send0(8'd12, 8'd34, 1'b1);
    send0(8'd200, 8'd100, 1'b0);
    rst0 = 1'b1;
    @(posedge clk);
    #1;
    rst0 = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", longint'(ov0), 0);
    chk("midrst_out_count", longint'(cnt0), 0);
    chk("midrst_in_ready", longint'(ir0), 1);
    repeat (6) begin
      @(negedge clk);
      chk("midrst_no_output", longint'(ov0), 0);
    end
    @(posedge clk);
    #1;

    // parameter sweep: exhaustive 4-bit (both modes), random 16-bit with bubbles
    for (int c = 0; c < 10000; c++) begin
      iva = 1'b1;
      xa  = 4'(c);
      ya  = 4'(c >> 4);
      iaa = 1'((c >> 8) & 1);
      ivb = ($urandom_range(0, 7) != 0);
      xb  = ($urandom_range(0, 31) == 0) ? 16'd0 : 16'($urandom);
      yb  = ($urandom_range(0, 31) == 0) ? 16'd0 : 16'($urandom);
      iab = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
    end
    iva = 1'b0;
    ivb = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("a_all_delivered", longint'(wp[1] - rp[1]), 0);
    chk("b_all_delivered", longint'(wp[2] - rp[2]), 0);
    chk("a_count", longint'(cnta), longint'(wp[1] > 65535 ? 65535 : wp[1]));
    chk("b_count", longint'(cntb), longint'(wp[2]));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/approx_mult_pipe.md
Name: approx_mult_pipe

Overview:
- Parametrised, pipelined unsigned approximate multiplier; next generation of the team's fixed 8x8 combinational approximate multipliers.
- Generalised in operand width, approximation depth and pipeline depth.
- Adds a per-transaction exact/approximate mode, a valid/ready stream interface and a per-result error output.
- Sits in datapaths that trade accuracy for power, and in accuracy-characterisation benches.

Parameters:
- WIDTH, 8, operand width in bits (4..16).
- APPROX_L, 6, partial-product columns 0..APPROX_L-1 dropped in approximate mode (0..2*WIDTH-1).
- PIPE_STAGES, 2, register stages from input to output; equals the latency (1..4).

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input operands valid.
- in_ready  out  1  block accepts input this cycle.
- in_x  in  WIDTH  multiplicand, unsigned.
- in_y  in  WIDTH  multiplier, unsigned.
- in_approx  in  1  1 = approximate product, 0 = exact product.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_z  out  2*WIDTH  product, unsigned.
- out_approx  out  1  mode bit carried with the result.
- out_err  out  2*WIDTH  signed two's complement: exact product minus out_z.
- out_count  out  16  saturating count of results delivered (out_valid & out_ready).

Behaviour:
- Reset (synchronous, active-high): all stage-valid bits, out_valid, out_z, out_approx, out_err and out_count go to 0. in_ready is 1 in the cycle after reset.
- Reset asserted mid-operation discards every in-flight transaction with no output.

Arithmetic:
- Exact mode: out_z = in_x*in_y, out_err = 0.
- Approximate mode:
  - D = sum over i,j of (x[i]&y[j])<<(i+j) for i+j < APPROX_L.
  - out_z = in_x*in_y - D + C, with C = 2^(APPROX_L-1) when APPROX_L>0, else 0.
  - out_err = D - C.
- Zero forcing: if in_x==0 or in_y==0, out_z = 0 and out_err = 0 in both modes.
- APPROX_L = 0: approximate mode is bit-identical to exact mode.
- Overflow: out_z never exceeds 2*WIDTH bits. C < 2^APPROX_L <= D_max + 1 is guaranteed for all legal parameters.

Pipeline and handshake:
- PIPE_STAGES register slices, each with its own valid bit.
- Global stall: adv = !out_valid || out_ready; in_ready = adv.
- When adv=1, every stage shifts forward one slice. A transfer occurs when in_valid & in_ready.
- When adv=0, every stage holds. out_z, out_err and out_approx stay stable while out_valid=1 and out_ready=0.
- Latency: a result is presented on out_valid exactly PIPE_STAGES cycles after acceptance if no stall occurs. Throughput is 1 per cycle.
- Bubbles (in_valid=0 while adv=1) propagate as invalid slices. Results are delivered in order.
- The internal split of partial-product generation and reduction across stages is free. Only the latency and the values are fixed.
- out_count increments on each out_valid & out_ready and saturates at 16'hFFFF.
- Inputs are sampled only on a transfer cycle; in_x/in_y/in_approx changes while in_ready=0 have no effect.

Test Plan:
- Defaults, exact mode: x=255, y=255, approx=0 -> out_z=65025, out_err=0, out_valid exactly 2 cycles after acceptance.
- Defaults, approximate mode: x=255, y=255, approx=1 -> D=321, out_z=64736, out_err=289. Then x=3, y=3, approx=1 -> out_z=32, out_err=-23 (16'hFFE9).
- Zero forcing: x=0, y=200 and x=77, y=0, approx=1 -> out_z=0, out_err=0.
- Stream and stall:
  - Stimulus: 20 back-to-back random transactions with mixed modes; out_ready low for cycles 5-7.
  - Required: in_ready low during the stall, no loss or duplication, outputs held stable while stalled, order preserved, every result matches the reference model, out_count=20.
- Reset mid-flight: 2 transactions accepted, rst pulsed one cycle -> no out_valid afterward, out_count=0, in_ready=1 the next cycle.
- Parameter sweep: (WIDTH=4, APPROX_L=0, PIPE_STAGES=1), (WIDTH=16, APPROX_L=12, PIPE_STAGES=4), exhaustive or 10k random operands -> match model, latency equals PIPE_STAGES.
